exp_operation_unit: RTL
=======================

EXP_OPERATION_UNIT -- requirements
Module: exp_operation_unit

Interface
REQ-001 Parameter: EW, default 8, exponent field width.
REQ-002 Parameter: BIAS, default 127, exponent bias subtracted once per operation.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  operation request, sampled only in IDLE.
REQ-006 exp_a  input  EW  biased exponent of operand A, captured on accepted start.
REQ-007 exp_b  input  EW  biased exponent of operand B, captured on accepted start.
REQ-008 norm_inc  input  1  mantissa-product overflow, adds +1 to exponent, captured with operands.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 result_exp  output  EW  biased result exponent.
REQ-012 overflow  output  1  result exponent >= 2^EW-1.
REQ-013 underflow  output  1  result exponent < 1.

Function
REQ-014 FSM states IDLE, ADD, BIAS, NORM, DONE; transitions IDLE->ADD on start, ADD->BIAS->NORM->DONE->IDLE unconditionally.
REQ-015 Operands and norm_inc registered on the edge that leaves IDLE; later input changes ignored until next accept.
REQ-016 Internal accumulator EW+2 bits signed; ADD: acc = a+b; BIAS: acc = acc-BIAS; NORM: acc = acc+norm_inc.
REQ-017 done asserted exactly 4 cycles after the edge accepting start (in DONE state), for one cycle only.
REQ-018 In DONE: overflow = (acc >= 2^EW-1); underflow = (acc < 1, including negative); both never simultaneously high.
REQ-019 result_exp, overflow, underflow registered on entering DONE and held stable until the next DONE.
REQ-020 start while busy (including in DONE) ignored, no queuing; back-to-back throughput one operation per 5 cycles.
REQ-021 start high continuously: new operation accepted on first IDLE cycle after DONE.

Reset
REQ-022 rst_n low: state IDLE, busy 0, done 0, result_exp 0, overflow 0, underflow 0, accumulator 0, immediately and independent of clk.
REQ-023 Reset mid-operation aborts it; no done pulse for the aborted operation; first start after release behaves normally.

Configuration
REQ-024 Macro EXP_SATURATE_EN defined: on overflow result_exp = all ones; on underflow result_exp = 0.
REQ-025 EXP_SATURATE_EN undefined: result_exp = acc[EW-1:0] unmodified; flags computed identically.

Structure
REQ-026 Shared package holds FSM state enumeration, default EW and BIAS constants.
REQ-027 One sub-module exp_addsub: single EW+2-bit adder/subtractor with op-select, reused in ADD, BIAS, NORM states; no second adder in the block.

Verification
REQ-028 exp_a=130, exp_b=127, norm_inc=0 -> done 4 cycles after start, result_exp=130, flags 0.
REQ-029 exp_a=127, exp_b=127, norm_inc=1 -> result_exp=128, flags 0.
REQ-030 exp_a=191, exp_b=190: norm_inc=0 -> 254 no flags; norm_inc=1 -> overflow=1, result_exp=255 (saturated).
REQ-031 exp_a=63, exp_b=64: norm_inc=0 -> underflow=1, result_exp=0; norm_inc=1 -> result_exp=1, flags 0.
REQ-032 exp_a=60, exp_b=60 (acc=-7) -> underflow=1, result_exp=0 with EXP_SATURATE_EN, raw low bits 0xF9 without.
REQ-033 start pulses during BIAS and DONE ignored; rst_n low during NORM -> no done, all outputs 0, next start gives correct result.

Source files
------------

// File: rtl/exp_operation_unit_pkg.sv
// Shared constants for the exponent operation unit: FSM state encoding and default widths.
// The unit honours the EXP_SATURATE_EN macro (saturating result exponent) in rtl/exp_operation_unit.sv.
package exp_operation_unit_pkg;

  localparam int DEF_EW   = 8;
  localparam int DEF_BIAS = 127;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADD  = 3'd1;
  localparam logic [2:0] ST_BIAS = 3'd2;
  localparam logic [2:0] ST_NORM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/exp_operation_unit_if.sv
// Request/result bundle of the exponent operation unit; master drives requests, slave is the unit.
interface exp_operation_unit_if
  import exp_operation_unit_pkg::*;
#(
  parameter int EW = DEF_EW
);

  logic          start;
  logic [EW-1:0] exp_a;
  logic [EW-1:0] exp_b;
  logic          norm_inc;
  logic          busy;
  logic          done;
  logic [EW-1:0] result_exp;
  logic          overflow;
  logic          underflow;

  modport master (
    output start, exp_a, exp_b, norm_inc,
    input  busy, done, result_exp, overflow, underflow
  );

  modport slave (
    input  start, exp_a, exp_b, norm_inc,
    output busy, done, result_exp, overflow, underflow
  );

endinterface

// File: rtl/exp_operation_unit_addsub.sv
// Single shared adder/subtractor (two's-complement: invert b and carry in on subtract).
module exp_addsub #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/exp_operation_unit.sv
// Exponent operation unit: (a + b - BIAS + norm_inc) over a 5-state FSM sharing one adder.
// Define EXP_SATURATE_EN to clamp result_exp to all-ones on overflow and zero on underflow.
module exp_operation_unit
  import exp_operation_unit_pkg::*;
#(
  parameter int EW   = DEF_EW,
  parameter int BIAS = DEF_BIAS
) (
  input logic                 clk,
  input logic                 rst_n,
  exp_operation_unit_if.slave bus
);

  localparam int AW = EW + 2;
  localparam logic signed [AW-1:0] BIAS_W  = AW'(BIAS);
  localparam logic signed [AW-1:0] OVF_LIM = AW'((1 << EW) - 1);
  localparam logic signed [AW-1:0] ONE_W   = {{(AW-1){1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [EW-1:0]         exp_a_q, exp_a_d;
  logic [EW-1:0]         exp_b_q, exp_b_d;
  logic                  norm_inc_q, norm_inc_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [EW-1:0]         result_q, result_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic signed [AW-1:0]  add_a_s, add_b_s, add_y_s;
  logic                  add_sub_s;
  logic                  ovf_s, unf_s;
  logic [EW-1:0]         result_sel_s;

  // Steer the shared adder according to the current step.
  always_comb begin
    add_a_s   = '0;
    add_b_s   = '0;
    add_sub_s = 1'b0;
    case (state_q)
      ST_ADD: begin
        add_a_s = {2'b00, exp_a_q};
        add_b_s = {2'b00, exp_b_q};
      end
      ST_BIAS: begin
        add_a_s   = acc_q;
        add_b_s   = BIAS_W;
        add_sub_s = 1'b1;
      end
      ST_NORM: begin
        add_a_s = acc_q;
        add_b_s = {{(AW-1){1'b0}}, norm_inc_q};
      end
      default: begin
        add_a_s   = '0;
        add_b_s   = '0;
        add_sub_s = 1'b0;
      end
    endcase
  end

  exp_addsub #(.W(AW)) u_addsub (
    .a   (add_a_s),
    .b   (add_b_s),
    .sub (add_sub_s),
    .y   (add_y_s)
  );

  // Flags and result exponent from the final (NORM) adder output.
  always_comb begin
    ovf_s = (add_y_s >= OVF_LIM);
    unf_s = (add_y_s < ONE_W);
`ifdef EXP_SATURATE_EN
    if (ovf_s) begin
      result_sel_s = {EW{1'b1}};
    end else if (unf_s) begin
      result_sel_s = '0;
    end else begin
      result_sel_s = add_y_s[EW-1:0];
    end
`else
    result_sel_s = add_y_s[EW-1:0];
`endif
  end

  // FSM sequencing, operand capture and result registration.
  always_comb begin
    state_d    = state_q;
    exp_a_d    = exp_a_q;
    exp_b_d    = exp_b_q;
    norm_inc_d = norm_inc_q;
    acc_d      = acc_q;
    done_d     = 1'b0;
    result_d   = result_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_ADD;
          exp_a_d    = bus.exp_a;
          exp_b_d    = bus.exp_b;
          norm_inc_d = bus.norm_inc;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        acc_d   = add_y_s;
        state_d = ST_BIAS;
      end
      ST_BIAS: begin
        acc_d   = add_y_s;
        state_d = ST_NORM;
      end
      ST_NORM: begin
        acc_d    = add_y_s;
        state_d  = ST_DONE;
        done_d   = 1'b1;
        result_d = result_sel_s;
        ovf_d    = ovf_s;
        unf_d    = unf_s;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      exp_a_q    <= '0;
      exp_b_q    <= '0;
      norm_inc_q <= 1'b0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_a_q    <= exp_a_d;
      exp_b_q    <= exp_b_d;
      norm_inc_q <= norm_inc_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result_exp = result_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;

endmodule
